// File: rtl/fp_sum_normalize.sv
// ============================================================================
// fp_sum_normalize
// ----------------------------------------------------------------------------
// Post-adder recovery stage of the FP add/sub datapath. It sits between the
// mantissa adder and the rounding stage.
//
// The incoming signed mantissa sum is split into a sign and a magnitude. The
// magnitude is then normalized by a small FSM that makes one decision per
// cycle and adjusts the exponent to match:
//   - zero result              -> flagged as exact zero
//   - carry into bit MANT_W    -> one right shift (with sticky), exp + 1,
//                                 saturating to all-ones on overflow
//   - hidden bit already set   -> done
//   - exponent at its minimum  -> stop as a denormal
//   - otherwise                -> one left shift, exp - 1, try again
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   in_valid     input transfer request
//   in_ready     high only while idle (registered, 0 during reset)
//   in_sum       signed two's-complement adder result, MANT_W+2 bits;
//                bit MANT_W+1 is the sign, bit MANT_W the carry position
//   in_exp       biased exponent of the larger operand
//   in_sign      sign of the non-complemented (larger) operand
//   out_valid    result available; high only in DONE
//   out_ready    downstream accept
//   out_sign     result sign
//   out_exp      result biased exponent
//   out_mant     normalized mantissa, hidden bit at the MSB
//   out_sticky   OR of the bit dropped by a right shift
//   out_zero     exact zero result
//   out_denorm   normalization stopped at the minimum exponent
//   out_overflow exponent saturated to all-ones
//
// Latency from the accepting edge: 2 cycles for zero / no shift / right
// shift, 2+N cycles for N left shifts (at most 2+(MANT_W-1)).
// ============================================================================
module fp_sum_normalize #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W+1:0] in_sum,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic              in_sign,

    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_mant,
    output logic              out_sticky,
    output logic              out_zero,
    output logic              out_denorm,
    output logic              out_overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [EXP_W-1:0] EXP_ALL_ONES = '1;
    // Largest exponent that may still be incremented without saturating.
    localparam logic [EXP_W-1:0] EXP_SAT_EDGE = EXP_ALL_ONES - EXP_W'(1);
    localparam logic [EXP_W-1:0] EXP_MIN      = EXP_W'(1);

    state_t            state;
    logic [MANT_W:0]   mag;
    logic [EXP_W-1:0]  exp_q;
    logic              sign_q;
    logic              sticky_q;
    logic              zero_q;
    logic              denorm_q;
    logic              overflow_q;

    // Magnitude of the incoming sum at full width. Only the most negative
    // value (-2^(MANT_W+1)) does not fit after truncation; it is outside the
    // legal input range.
    logic [MANT_W+1:0] sum_abs;
    logic              accept;

    assign sum_abs = in_sum[MANT_W+1] ? ((~in_sum) + (MANT_W+2)'(1)) : in_sum;
    assign accept  = in_valid && in_ready;

    // ------------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------------
    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others, whatever the
    // statement order inside the block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the datapath registers are reset along with the control
            // state because they drive outputs directly, and every output
            // must read 0 while reset is asserted.
            state      <= S_IDLE;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            mag        <= '0;
            exp_q      <= '0;
            sign_q     <= 1'b0;
            sticky_q   <= 1'b0;
            zero_q     <= 1'b0;
            denorm_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mag        <= sum_abs[MANT_W:0];
                        sign_q     <= in_sign ^ in_sum[MANT_W+1];
                        // Exponent 0 denotes a denormal operand whose true
                        // scale is that of exponent 1.
                        exp_q      <= (in_exp == '0) ? EXP_MIN : in_exp;
                        sticky_q   <= 1'b0;
                        zero_q     <= 1'b0;
                        denorm_q   <= 1'b0;
                        overflow_q <= 1'b0;
                        in_ready   <= 1'b0;
                        state      <= S_NORM;
                    end else begin
                        // Also raises in_ready on the first edge after reset.
                        in_ready <= 1'b1;
                    end
                end

                S_NORM: begin
                    if (mag == '0) begin
                        zero_q    <= 1'b1;
                        sign_q    <= 1'b0;
                        exp_q     <= '0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else if (mag[MANT_W]) begin
                        // Carry out of the hidden-bit position: one right
                        // shift always suffices for a two-operand sum.
                        sticky_q <= mag[0];
                        if (exp_q == EXP_SAT_EDGE) begin
                            exp_q      <= EXP_ALL_ONES;
                            mag        <= '0;
                            overflow_q <= 1'b1;
                        end else begin
                            mag   <= mag >> 1;
                            exp_q <= exp_q + EXP_W'(1);
                        end
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else if (mag[MANT_W-1]) begin
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else if (exp_q == EXP_MIN) begin
                        // Cannot shift further without going below the
                        // minimum exponent: leave the mantissa denormal.
                        exp_q     <= '0;
                        denorm_q  <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        mag   <= mag << 1;
                        exp_q <= exp_q - EXP_W'(1);
                    end
                end

                S_DONE: begin
                    // in_ready is raised together with the return to IDLE, so
                    // no new operand can be taken in the releasing cycle.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping: straight from registers, so outputs hold in DONE.
    // ------------------------------------------------------------------------
    assign out_sign     = sign_q;
    assign out_exp      = exp_q;
    assign out_mant     = mag[MANT_W-1:0];
    assign out_sticky   = sticky_q;
    assign out_zero     = zero_q;
    assign out_denorm   = denorm_q;
    assign out_overflow = overflow_q;

endmodule

// File: tb/tb_fp_sum_normalize.sv
// ============================================================================
// tb_fp_sum_normalize
// Self-checking bench for fp_sum_normalize (MANT_W=24, EXP_W=8).
// Directed table vectors, hand-written backpressure / reset sequences and
// randomized transactions compared with a closed-form reference model.
// ============================================================================
module tb_fp_sum_normalize;

    localparam int MANT_W = 24;
    localparam int EXP_W  = 8;

    logic              clk;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [MANT_W+1:0] in_sum;
    logic [EXP_W-1:0]  in_exp;
    logic              in_sign;
    logic              out_valid;
    logic              out_ready;
    logic              out_sign;
    logic [EXP_W-1:0]  out_exp;
    logic [MANT_W-1:0] out_mant;
    logic              out_sticky;
    logic              out_zero;
    logic              out_denorm;
    logic              out_overflow;

    fp_sum_normalize #(.MANT_W(MANT_W), .EXP_W(EXP_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sum       (in_sum),
        .in_exp       (in_exp),
        .in_sign      (in_sign),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sign     (out_sign),
        .out_exp      (out_exp),
        .out_mant     (out_mant),
        .out_sticky   (out_sticky),
        .out_zero     (out_zero),
        .out_denorm   (out_denorm),
        .out_overflow (out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {sign, exp, mant, sticky, zero, denorm, overflow}
    logic [36:0] dut_res;
    assign dut_res = {out_sign, out_exp, out_mant, out_sticky, out_zero, out_denorm, out_overflow};

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [25:0] v_sum;
        logic [7:0]  v_exp;
        logic        v_sign;
        logic [36:0] v_res;
        int          v_lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic logic [36:0] pack(input logic s, input logic [7:0] e, input logic [23:0] m,
                                         input logic st, input logic z, input logic dn, input logic ov);
        return {s, e, m, st, z, dn, ov};
    endfunction

    // Reference: recover |sum|, then either right-shift once, or compute the
    // required left shift from the leading-one position and clip it to the
    // available exponent range.
    task automatic model(input logic [25:0] s_sum, input logic [7:0] s_exp, input logic s_sign,
                         output logic [36:0] res, output int lat);
        logic [25:0] a;
        logic [24:0] m;
        logic [24:0] t;
        logic        s;
        int          e;
        int          p;
        int          sh;
        a = s_sum[25] ? (26'd0 - s_sum) : s_sum;
        m = a[24:0];
        s = s_sign ^ s_sum[25];
        e = (s_exp == 8'd0) ? 1 : int'(s_exp);
        lat = 2;
        if (m == 25'd0) begin
            res = pack(1'b0, 8'd0, 24'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        end else if (m[24]) begin
            if (e == 254) res = pack(s, 8'hFF, 24'd0, m[0], 1'b0, 1'b0, 1'b1);
            else          res = pack(s, 8'(e + 1), m[24:1], m[0], 1'b0, 1'b0, 1'b0);
        end else begin
            p = 23;
            while (!m[p]) p--;
            sh = 23 - p;
            if (sh <= e - 1) begin
                t   = m << sh;
                res = pack(s, 8'(e - sh), t[23:0], 1'b0, 1'b0, 1'b0, 1'b0);
                lat = 2 + sh;
            end else begin
                t   = m << (e - 1);
                res = pack(s, 8'd0, t[23:0], 1'b0, 1'b0, 1'b1, 1'b0);
                lat = 2 + (e - 1);
            end
        end
    endtask

    // Waits for in_ready, transfers one operand, then waits (bounded) for
    // out_valid. Returns with the DUT holding its result in DONE.
    task automatic do_txn(input logic [25:0] s_sum, input logic [7:0] s_exp, input logic s_sign,
                          output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        in_sum   = s_sum;
        in_exp   = s_exp;
        in_sign  = s_sign;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!out_valid && n < 40);
        check("out_valid_within_bound", 64'(out_valid), 64'd1);
        lat = n + 1;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [36:0] want;
        logic [36:0] snap;
        logic [25:0] r_mag;
        logic [25:0] r_sum;
        logic [7:0]  r_exp;
        logic        r_sign;
        int          lat;
        int          want_lat;
        int          w;

        vecs[0]  = '{26'h0800000, 8'd127, 1'b0, pack(1'b0, 8'd127, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0), 2};
        vecs[1]  = '{26'h3C00000, 8'd130, 1'b0, pack(1'b1, 8'd129, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0), 3};
        vecs[2]  = '{26'h1000001, 8'd100, 1'b0, pack(1'b0, 8'd101, 24'h800000, 1'b1, 1'b0, 1'b0, 1'b0), 2};
        vecs[3]  = '{26'h1000001, 8'd254, 1'b0, pack(1'b0, 8'd255, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b1), 2};
        vecs[4]  = '{26'h0000000, 8'd50,  1'b1, pack(1'b0, 8'd0,   24'h000000, 1'b0, 1'b1, 1'b0, 1'b0), 2};
        vecs[5]  = '{26'h0000001, 8'd3,   1'b0, pack(1'b0, 8'd0,   24'h000004, 1'b0, 1'b0, 1'b1, 1'b0), 4};
        vecs[6]  = '{26'h0000001, 8'd127, 1'b0, pack(1'b0, 8'd104, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0), 25};
        vecs[7]  = '{26'h0800000, 8'd0,   1'b0, pack(1'b0, 8'd1,   24'h800000, 1'b0, 1'b0, 1'b0, 1'b0), 2};
        vecs[8]  = '{26'h0400000, 8'd0,   1'b0, pack(1'b0, 8'd0,   24'h400000, 1'b0, 1'b0, 1'b1, 1'b0), 2};
        vecs[9]  = '{26'h3FFFFFF, 8'd10,  1'b1, pack(1'b0, 8'd0,   24'h000200, 1'b0, 1'b0, 1'b1, 1'b0), 11};
        vecs[10] = '{26'h2FFFFFE, 8'd60,  1'b0, pack(1'b1, 8'd61,  24'h800001, 1'b0, 1'b0, 1'b0, 1'b0), 2};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_exp    = '0;
        in_sign   = 1'b0;
        out_ready = 1'b0;

        // Reset state: every output low, including in_ready.
        #12;
        check("reset_outputs", 64'({in_ready, out_valid, dut_res}), 64'd0);
        #10 reset_n = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready", 64'(in_ready), 64'd1);

        // Directed table.
        for (int i = 0; i < 11; i++) begin
            do_txn(vecs[i].v_sum, vecs[i].v_exp, vecs[i].v_sign, lat);
            check($sformatf("vec%0d_result", i), 64'(dut_res), 64'(vecs[i].v_res));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].v_lat));
            release_out();
        end

        // Backpressure: DONE holds, in_ready stays low, new in_valid ignored.
        do_txn(26'h3C00000, 8'd130, 1'b0, lat);
        snap = dut_res;
        check("bp_initial", 64'(snap), 64'(pack(1'b1, 8'd129, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0)));
        in_sum   = 26'h0000001;
        in_exp   = 8'd9;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d", k), 64'({out_valid, in_ready, dut_res}), 64'({1'b1, 1'b0, snap}));
        end
        in_valid = 1'b0;
        release_out();
        check("bp_released", 64'({out_valid, in_ready}), 64'b01);

        // Reset asserted in the middle of a long normalization.
        in_sum   = 26'h0000001;
        in_exp   = 8'd127;
        in_sign  = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_norm_busy", 64'({out_valid, in_ready}), 64'd0);
        reset_n = 1'b0;
        #1;
        check("mid_norm_reset", 64'({in_ready, out_valid, dut_res}), 64'd0);
        @(posedge clk); #1;
        check("mid_norm_reset_hold", 64'({in_ready, out_valid, dut_res}), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_ready", 64'({in_ready, out_valid}), 64'b10);
        do_txn(26'h0800000, 8'd127, 1'b0, lat);
        check("post_reset_result", 64'(dut_res), 64'(pack(1'b0, 8'd127, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0)));
        release_out();

        // Randomized transactions against the reference model.
        for (int i = 0; i < 200; i++) begin
            w      = $urandom_range(0, 25);
            r_mag  = 26'($urandom) & ((26'd1 << w) - 26'd1);
            r_sum  = $urandom_range(0, 1) ? (26'd0 - r_mag) : r_mag;
            r_exp  = 8'($urandom_range(0, 254));
            r_sign = 1'($urandom_range(0, 1));
            model(r_sum, r_exp, r_sign, want, want_lat);
            do_txn(r_sum, r_exp, r_sign, lat);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            check($sformatf("rand%0d_result sum=%h exp=%0d", i, r_sum, r_exp), 64'(dut_res), 64'(want));
            check($sformatf("rand%0d_latency", i), 64'(lat), 64'(want_lat));
            release_out();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fp_sum_normalize.md
# fp_sum_normalize

Post-adder recovery stage of the FP add/sub datapath. It takes the signed mantissa sum produced after the operand two's-complement step, recovers sign and magnitude, then normalizes the magnitude with a multi-cycle shift FSM while adjusting the exponent. It sits between the mantissa adder and the rounding stage, with valid/ready handshakes on both sides.

## Interface

Parameters:
- MANT_W, 24: mantissa width, including the hidden bit.
- EXP_W, 8: biased exponent width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input transfer request.
- in_ready  out  1  high only in IDLE.
- in_sum  in  MANT_W+2  signed two's-complement adder result. Bit MANT_W+1 is the sign; bit MANT_W is the carry position.
- in_exp  in  EXP_W  exponent of the larger operand.
- in_sign  in  1  sign of the non-complemented (larger) operand.
- out_valid  out  1  result available; high only in DONE.
- out_ready  in  1  downstream accept.
- out_sign  out  1  result sign.
- out_exp  out  EXP_W  result biased exponent.
- out_mant  out  MANT_W  normalized mantissa, hidden bit at MSB.
- out_sticky  out  1  OR of bits shifted out on a right shift.
- out_zero  out  1  exact zero result.
- out_denorm  out  1  normalization stopped at the minimum exponent.
- out_overflow  out  1  exponent saturated to all-ones.

## Operation

States: IDLE, NORM, DONE. Reset state is IDLE.

**IDLE**
- in_ready=1.
- On in_valid&in_ready, register:
  - mag = |in_sum|, MANT_W+1 bits.
  - sign = in_sign ^ in_sum[MSB].
  - exp = in_exp; an in_exp of 0 is loaded as 1.
- Clear sticky and all flags, then go to NORM.

**NORM** — one decision per cycle, priority order:
1. mag==0: out_zero=1, sign=0, exp=0 → DONE.
2. mag[MANT_W]=1:
   - mag>>=1; sticky=dropped bit.
   - If exp==2^EXP_W-2: exp=all-ones, mant=0, out_overflow=1. Otherwise exp+=1.
   - → DONE.
3. mag[MANT_W-1]=1: already normalized → DONE.
4. exp==1: exp=0, out_denorm=1, mantissa unchanged → DONE.
5. Otherwise: mag<<=1, exp-=1, stay in NORM.

**DONE**
- out_valid=1; outputs hold stable.
- On out_ready → IDLE. in_ready stays 0 during DONE, so there is no same-cycle re-accept.

**Output mapping and widths**
- out_mant = mag[MANT_W-1:0].
- The magnitude is computed at MANT_W+2 bits, then truncated to MANT_W+1 bits. The maximum legal |in_sum| is 2^(MANT_W+1)-1.
- Exponent arithmetic is unsigned EXP_W bits. By the guards above it never wraps.

## Timing

- All outputs reset to 0: in_ready=0 during reset, then 1 in IDLE once reset releases.
- Accept at edge E0. For N left shifts, out_valid rises after edge E(1+N):
  - Latency 2 cycles with no shift, zero, or right shift.
  - Latency 2+N with N left shifts.
  - Maximum 2+(MANT_W-1)=25 cycles.
- Backpressure: with out_ready=0, DONE holds indefinitely with outputs unchanged.
- Reset asserted in any state: immediate return to IDLE, all outputs 0, in-flight result discarded.
- in_valid while busy: ignored, since in_ready=0. The source must hold its data until it is accepted.

## Test plan

- **Normalized positive:** in_sum=0x0800000, exp=127, in_sign=0 → sign 0, exp 127, mant 0x800000, no flags, out_valid 2 cycles after accept.
- **Negative sum:** in_sum=-0x400000 (0x3C00000), exp=130, in_sign=0 → sign 1, exp 129, mant 0x800000, latency 3.
- **Carry with sticky and overflow:**
  - in_sum=0x1000001, exp=100 → exp 101, mant 0x800000, sticky 1, latency 2.
  - Same in_sum with exp=254 → exp 255, mant 0, overflow 1.
- **Zero and underflow:**
  - in_sum=0, exp=50, in_sign=1 → zero 1, sign 0, exp 0, mant 0, latency 2.
  - in_sum=1, exp=3 → two left shifts, exp 0, mant 0x000004, denorm 1.
- **Max-latency, backpressure and reset:**
  - in_sum=1, exp=127 → mant 0x800000, exp 104, out_valid at 25 cycles.
  - Hold out_ready=0 for 10 cycles → outputs stable, in_ready=0.
  - Deassert reset_n mid-NORM → next cycle all outputs 0, then IDLE with in_ready=1 once reset releases.
